// File: rtl/console_fifo.sv
// Memory-mapped console output buffer: CPU bus writes queue bytes, host drains them as a valid/ready byte stream.
// Bus ack one cycle after the request is taken; full DATA writes stall (BLOCKING=1) or are dropped with a sticky flag.
module console_fifo #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] ADDR_DATA   = 32'h1000_0000,
  parameter logic [31:0] ADDR_STATUS = 32'h1000_0004,
  parameter int          BLOCKING    = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     sel,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t          state;
  logic [7:0]      buffer [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            dropped;

  logic            hit_data;
  logic            hit_status;
  logic            is_write;
  logic            full;
  logic            empty;
  logic            accept;
  logic            start;
  logic            do_push;
  logic            do_pop;
  logic [31:0]     status_word;
  logic            unused_wdata;

  assign hit_data   = (mem_addr == ADDR_DATA);
  assign hit_status = (mem_addr == ADDR_STATUS);
  assign is_write   = |mem_wstrb;
  assign sel        = mem_valid && (hit_data || hit_status);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Only a DATA write in blocking mode waits for room; the check uses registered count.
  assign accept  = sel && (!is_write || hit_status || (BLOCKING == 0) || !full);
  assign start   = (state == IDLE) && accept;
  assign do_push = start && is_write && hit_data && mem_wstrb[0] && !full;
  assign do_pop  = !empty && out_ready;

  assign out_valid = !empty;
  assign out_data  = buffer[rd_ptr];

  assign status_word  = {dropped, 13'd0, empty, full, {(16-CW){1'b0}}, count};
  assign unused_wdata = ^mem_wdata[30:8];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      dropped   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_rdata <= (!is_write && hit_status) ? status_word : '0;
            if (is_write && hit_data && mem_wstrb[0] && full)
              dropped <= 1'b1;
            if (is_write && hit_status && mem_wdata[31])
              dropped <= 1'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Storage is deliberately left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) buffer[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (resetn) assert (count <= CW'(DEPTH));
  end

endmodule

// File: tb/tb_console_fifo.sv
// Scoreboard bench for console_fifo: one blocking and one dropping instance share the bus lines.
module tb_console_fifo;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] A_DATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        valid_b = 1'b0, valid_n = 1'b0;
  logic        ordy_b = 1'b0, ordy_n = 1'b0;

  logic        sel_b, ready_b, ovalid_b, sel_n, ready_n, ovalid_n;
  logic [31:0] rdata_b, rdata_n;
  logic [7:0]  odata_b, odata_n;
  logic [4:0]  count_b, count_n;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  exp_b[$];
  logic [7:0]  exp_n[$];

  always #5 clk = ~clk;

  console_fifo #(.DEPTH(DEPTH), .ADDR_DATA(A_DATA), .ADDR_STATUS(A_STAT), .BLOCKING(1)) dut_b (
    .clk(clk), .resetn(resetn), .mem_valid(valid_b), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .sel(sel_b), .mem_ready(ready_b), .mem_rdata(rdata_b),
    .out_valid(ovalid_b), .out_data(odata_b), .out_ready(ordy_b), .count(count_b));

  console_fifo #(.DEPTH(DEPTH), .ADDR_DATA(A_DATA), .ADDR_STATUS(A_STAT), .BLOCKING(0)) dut_n (
    .clk(clk), .resetn(resetn), .mem_valid(valid_n), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .sel(sel_n), .mem_ready(ready_n), .mem_rdata(rdata_n),
    .out_valid(ovalid_n), .out_data(odata_n), .out_ready(ordy_n), .count(count_n));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
  endtask

  // Every byte the host takes is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (ovalid_b && ordy_b) begin
      if (exp_b.size() == 0) check("sb_b_extra", 1, 0);
      else check("sb_b_data", {24'd0, odata_b}, {24'd0, exp_b.pop_front()});
    end
    if (ovalid_n && ordy_n) begin
      if (exp_n.size() == 0) check("sb_n_extra", 1, 0);
      else check("sb_n_data", {24'd0, odata_n}, {24'd0, exp_n.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_start(input bit nb, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a;
    wdata = d;
    wstrb = s;
    if (nb) valid_n = 1'b1;
    else    valid_b = 1'b1;
  endtask

  task automatic bus_drop();
    valid_b = 1'b0;
    valid_n = 1'b0;
    wstrb = '0;
  endtask

  // lat counts clock edges from the request being presented to mem_ready being seen.
  task automatic bus_wait(input bit nb, input int max, output bit got, output logic [31:0] rd, output int lat);
    got = 1'b0;
    rd = '0;
    lat = 0;
    for (int i = 1; i <= max && !got; i++) begin
      @(negedge clk);
      if (nb ? ready_n : ready_b) begin
        got = 1'b1;
        lat = i - 1;
        rd = nb ? rdata_n : rdata_b;
      end
    end
    if (got) begin
      step();
      bus_drop();
    end
  endtask

  task automatic xfer(input bit nb, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input string tag, output logic [31:0] rd);
    bit got;
    int lat;
    bus_start(nb, a, d, s);
    bus_wait(nb, 4, got, rd, lat);
    check({tag, "_ack"}, got, 1);
    if (got) check({tag, "_lat"}, lat, 1);
    else begin
      step();
      bus_drop();
    end
  endtask

  task automatic drain(input bit nb, input int max, input string tag);
    bit done = 1'b0;
    if (nb) ordy_n = 1'b1;
    else    ordy_b = 1'b1;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if ((nb ? count_n : count_b) == 0) done = 1'b1;
    end
    step();
    ordy_b = 1'b0;
    ordy_n = 1'b0;
    check({tag, "_drained"}, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    bit          got;
    int          lat;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count_b", count_b, 0);
    check("rst_ovalid_b", ovalid_b, 0);
    check("rst_ready_b", ready_b, 0);
    check("rst_rdata_b", rdata_b, 0);
    check("rst_count_n", count_n, 0);
    check("rst_sel_b", sel_b, 0);
    step();
    resetn = 1'b1;
    step();

    // Single write, ready pulse is one cycle wide
    exp_b.push_back(8'h41);
    bus_start(0, A_DATA, 32'h41, 4'b0001);
    bus_wait(0, 4, got, rd, lat);
    check("t1_ack", got, 1);
    check("t1_lat", lat, 1);
    @(negedge clk);
    check("t1_ready_one_cycle", ready_b, 0);
    check("t1_ovalid", ovalid_b, 1);
    check("t1_odata", {24'd0, odata_b}, 32'h41);
    check("t1_count", count_b, 1);
    step();
    drain(0, 8, "t1");

    // Fill, stall on the 17th byte, release with a single pop
    for (int i = 0; i < DEPTH; i++) begin
      exp_b.push_back(8'(i));
      xfer(0, A_DATA, i, 4'b0001, "fill", rd);
    end
    @(negedge clk);
    check("fill_count", count_b, DEPTH);
    step();
    exp_b.push_back(8'h10);
    bus_start(0, A_DATA, 32'h10, 4'b0001);
    repeat (4) begin
      @(negedge clk);
      check("stall_ready", ready_b, 0);
    end
    step();
    ordy_b = 1'b1;
    step();
    ordy_b = 1'b0;
    bus_wait(0, 4, got, rd, lat);
    check("stall_ack", got, 1);
    if (!got) begin
      step();
      bus_drop();
    end
    @(negedge clk);
    check("stall_count", count_b, DEPTH);
    step();
    drain(0, 40, "t2");
    check("t2_sb_empty", exp_b.size(), 0);

    // Dropping instance held full
    for (int i = 0; i < 20; i++) begin
      if (i < DEPTH) exp_n.push_back(8'(8'h20 + i));
      xfer(1, A_DATA, 32'h20 + i, 4'b0001, "nb_wr", rd);
    end
    xfer(1, A_STAT, 0, 4'b0000, "nb_st1", rd);
    check("nb_status_dropped", rd, 32'h8001_0010);
    xfer(1, A_STAT, 32'h8000_0000, 4'b1111, "nb_clr", rd);
    check("nb_clr_rdata", rd, 0);
    xfer(1, A_STAT, 0, 4'b0000, "nb_st2", rd);
    check("nb_status_cleared", rd, 32'h0001_0010);
    drain(1, 40, "t3");
    check("t3_sb_empty", exp_n.size(), 0);
    xfer(1, A_STAT, 0, 4'b0000, "nb_st3", rd);
    check("status_empty", rd, 32'h0002_0000);
    xfer(1, A_DATA, 0, 4'b0000, "data_rd", rd);
    check("data_read_zero", rd, 0);
    xfer(1, A_DATA, 32'hEE, 4'b0010, "no_lane0", rd);
    @(negedge clk);
    check("no_lane0_count", count_n, 0);
    step();

    // Streaming with the host always ready
    ordy_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_b.push_back(8'(8'h60 + i));
      xfer(0, A_DATA, 32'h60 + i, 4'b0001, "cont", rd);
      @(negedge clk);
      check("cont_count_le1", count_b <= 1, 1);
      step();
    end
    drain(0, 8, "t4");
    check("t4_sb_empty", exp_b.size(), 0);

    // Unmapped address
    bus_start(0, 32'h0000_1000, 32'h33, 4'b0001);
    @(negedge clk);
    check("nosel_sel", sel_b, 0);
    repeat (3) begin
      @(negedge clk);
      check("nosel_ready", ready_b, 0);
    end
    step();
    bus_drop();
    @(negedge clk);
    check("nosel_count", count_b, 0);
    step();

    // Reset while a full write is stalled
    for (int i = 0; i < DEPTH; i++) begin
      exp_b.push_back(8'(8'h70 + i));
      xfer(0, A_DATA, 32'h70 + i, 4'b0001, "rfill", rd);
    end
    bus_start(0, A_DATA, 32'h7F, 4'b0001);
    repeat (2) @(negedge clk);
    step();
    resetn = 1'b0;
    step();
    step();
    bus_drop();
    resetn = 1'b1;
    exp_b.delete();
    exp_n.delete();
    @(negedge clk);
    check("rst_mid_count", count_b, 0);
    check("rst_mid_ovalid", ovalid_b, 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_stale", ovalid_b, 0);
    end
    step();
    exp_b.push_back(8'h5A);
    xfer(0, A_DATA, 32'h5A, 4'b0001, "fresh", rd);
    @(negedge clk);
    check("fresh_count", count_b, 1);
    check("fresh_odata", {24'd0, odata_b}, 32'h5A);
    step();
    drain(0, 8, "t6");
    @(negedge clk);
    check("t6_ovalid", ovalid_b, 0);
    check("t6_sb_empty", exp_b.size(), 0);
    check("end_sb_n_empty", exp_n.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
